// File: rtl/alu_fu_cdb.sv
// ALU functional unit with an in-order result FIFO that feeds the CDB.
// Define FU_MUL_EN to make ALUOP 11 a MUL_CYCLES multi-cycle multiply; otherwise it yields 0.
module alu_fu_cdb #(
  parameter int DEPTH      = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RS_FU_RS_ID,
  input  logic [4:0]  RS_FU_ROBEN,
  input  logic [11:0] RS_FU_opcode,
  input  logic [3:0]  RS_FU_ALUOP,
  input  logic [31:0] RS_FU_Val1,
  input  logic [31:0] RS_FU_Val2,
  input  logic [31:0] RS_FU_Immediate,
  input  logic        ROB_FLUSH_Flag,
  input  logic        CDB_Grant,
  output logic        FU_Is_Free,
  output logic        CDB_Req,
  output logic [4:0]  CDB_ROBEN,
  output logic [31:0] CDB_VAL
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL,
    OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_MUL
  } alu_op_e;

  typedef enum logic {IDLE, MUL_BUSY} state_e;

  state_e        state;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic [4:0]    rob_mem [DEPTH];
  logic [31:0]   val_mem [DEPTH];

  logic [31:0] op_b, alu_res, push_val;
  logic [4:0]  push_rob;
  logic        accept, push, pop;

  // Only op6 selects the B operand; funct6 carries no meaning here.
  logic unused_funct;
  assign unused_funct = ^RS_FU_opcode[5:0];

  assign op_b = (RS_FU_opcode[11:6] == 6'd0) ? RS_FU_Val2 : RS_FU_Immediate;

  always_comb begin
    // NOTE: default first so every path assigns alu_res and no latch is inferred.
    alu_res = '0;
    case (alu_op_e'(RS_FU_ALUOP))
      OP_ADD:  alu_res = RS_FU_Val1 + op_b;
      OP_SUB:  alu_res = RS_FU_Val1 - op_b;
      OP_AND:  alu_res = RS_FU_Val1 & op_b;
      OP_OR:   alu_res = RS_FU_Val1 | op_b;
      OP_XOR:  alu_res = RS_FU_Val1 ^ op_b;
      OP_NOR:  alu_res = ~(RS_FU_Val1 | op_b);
      OP_SLL:  alu_res = RS_FU_Val1 << op_b[4:0];
      OP_SRL:  alu_res = RS_FU_Val1 >> op_b[4:0];
      OP_SRA:  alu_res = 32'($signed(RS_FU_Val1) >>> op_b[4:0]);
      OP_SLT:  alu_res = {31'd0, $signed(RS_FU_Val1) < $signed(op_b)};
      OP_SLTU: alu_res = {31'd0, RS_FU_Val1 < op_b};
      default: alu_res = '0;
    endcase
  end

  assign FU_Is_Free = (state == IDLE) && (count < (PW+1)'(DEPTH));
  assign accept     = (RS_FU_RS_ID != 5'd0) && FU_Is_Free && !ROB_FLUSH_Flag;
  assign CDB_Req    = (count != '0);
  assign pop        = CDB_Req && CDB_Grant && !ROB_FLUSH_Flag;
  assign CDB_ROBEN  = CDB_Req ? rob_mem[rd_ptr] : 5'd0;
  assign CDB_VAL    = CDB_Req ? val_mem[rd_ptr] : 32'd0;

`ifdef FU_MUL_EN
  localparam int CW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

  logic [CW-1:0] ctr;
  logic [4:0]    mul_rob;
  logic [31:0]   mul_a, mul_b;
  logic          is_mul, mul_done;

  assign is_mul   = (alu_op_e'(RS_FU_ALUOP) == OP_MUL);
  assign mul_done = (state == MUL_BUSY) && (ctr == '0);
  assign push     = (accept && !is_mul) || (mul_done && !ROB_FLUSH_Flag);
  assign push_rob = mul_done ? mul_rob : RS_FU_ROBEN;
  assign push_val = mul_done ? mul_a * mul_b : alu_res;

  always_ff @(posedge clk) begin
    if (rst || ROB_FLUSH_Flag) begin
      state <= IDLE;
      ctr   <= '0;
    end else begin
      case (state)
        IDLE: if (accept && is_mul) begin
          state   <= MUL_BUSY;
          ctr     <= CW'(MUL_CYCLES - 1);
          mul_rob <= RS_FU_ROBEN;
          mul_a   <= RS_FU_Val1;
          mul_b   <= op_b;
        end
        MUL_BUSY: begin
          if (ctr == '0) state <= IDLE;
          else           ctr   <= ctr - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign state    = IDLE;
  assign push     = accept;
  assign push_rob = RS_FU_ROBEN;
  assign push_val = alu_res;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || ROB_FLUSH_Flag) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      rob_mem[wr_ptr] <= push_rob;
      val_mem[wr_ptr] <= push_val;
    end
  end

endmodule

// File: tb/tb_alu_fu_cdb.sv
// Randomized bench for alu_fu_cdb against a queue-based reference model, plus directed scenarios.
module tb_alu_fu_cdb;

  localparam int DEPTH      = 4;
  localparam int MUL_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_id, roben;
  logic [11:0] opcode;
  logic [3:0]  aluop;
  logic [31:0] val1, val2, imm;
  logic        flush, grant;
  logic        fu_free, cdb_req;
  logic [4:0]  cdb_roben;
  logic [31:0] cdb_val;

  int checks   = 0;
  int failures = 0;

  logic [36:0] q[$];
  int          mul_left;
  logic [36:0] mul_entry;

  always #5 clk = ~clk;

  alu_fu_cdb #(.DEPTH(DEPTH), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .RS_FU_RS_ID(rs_id), .RS_FU_ROBEN(roben), .RS_FU_opcode(opcode),
    .RS_FU_ALUOP(aluop), .RS_FU_Val1(val1), .RS_FU_Val2(val2),
    .RS_FU_Immediate(imm), .ROB_FLUSH_Flag(flush), .CDB_Grant(grant),
    .FU_Is_Free(fu_free), .CDB_Req(cdb_req), .CDB_ROBEN(cdb_roben), .CDB_VAL(cdb_val)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh = int'(b % 32);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~(a | b);
      6:  return a << sh;
      7:  return a >> sh;
      8:  return $signed(a) >>> sh;
      9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      10: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit model_free();
    return (mul_left == 0) && (q.size() < DEPTH);
  endfunction

  task automatic compare_model(input string tag);
    logic [36:0] head;
    head = (q.size() != 0) ? q[0] : 37'd0;
    check({tag, ".free"},  32'(fu_free),   32'(model_free()));
    check({tag, ".req"},   32'(cdb_req),   32'(q.size() != 0));
    check({tag, ".roben"}, 32'(cdb_roben), 32'(head[36:32]));
    check({tag, ".val"},   32'(cdb_val),   head[31:0]);
  endtask

  // Advances the model by one edge using the inputs currently driven.
  task automatic model_edge();
    logic [31:0] b;
    bit          free_now;
    free_now = model_free();
    if (flush) begin
      q.delete();
      mul_left = 0;
    end else begin
      if (grant && q.size() != 0) void'(q.pop_front());
      if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) q.push_back(mul_entry);
      end else if (rs_id != 0 && free_now) begin
        b = (opcode[11:6] == 6'd0) ? val2 : imm;
`ifdef FU_MUL_EN
        if (aluop == 4'd11) begin
          mul_left  = MUL_CYCLES;
          mul_entry = {roben, val1 * b};
        end else
`endif
        q.push_back({roben, ref_alu(int'(aluop), val1, b)});
      end
    end
  endtask

  task automatic step(input string tag, input logic [4:0] id, input logic [4:0] rob,
                      input logic [5:0] op6, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] im, input logic fl, input logic gr);
    rs_id = id; roben = rob; opcode = {op6, 6'd0}; aluop = op;
    val1 = a; val2 = b; imm = im; flush = fl; grant = gr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model(tag);
  endtask

  task automatic idle(input string tag, input logic gr);
    step(tag, 5'd0, 5'd0, 6'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, gr);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; rs_id = '0; roben = '0; opcode = '0; aluop = '0;
    val1 = '0; val2 = '0; imm = '0; flush = 1'b0; grant = 1'b0;
    @(posedge clk);
    q.delete();
    mul_left = 0;
    @(negedge clk);
    rst = 1'b0;
    compare_model(tag);
  endtask

  initial begin
    mul_left = 0;
    do_reset("reset");
    check("reset.free_const", 32'(fu_free), 32'd1);
    check("reset.req_const",  32'(cdb_req), 32'd0);

    // ADD 5+7 with grant held: visible next cycle, popped on the following edge.
    step("add", 5'd1, 5'd3, 6'd0, 4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1);
    check("add.val_const",   cdb_val,          32'd12);
    check("add.roben_const", 32'(cdb_roben),   32'd3);
    idle("add.pop", 1'b1);
    check("add.popped", 32'(cdb_req), 32'd0);

    // Fill the FIFO without grant, then drain in order.
    for (int i = 1; i <= 4; i++)
      step("fill", 5'd1, 5'(i), 6'd0, 4'd0, 32'(i * 10), 32'd1, 32'd0, 1'b0, 1'b0);
    check("fill.not_free", 32'(fu_free), 32'd0);
    idle("drain1", 1'b1);
    check("drain1.free",  32'(fu_free),   32'd1);
    check("drain1.head",  32'(cdb_roben), 32'd2);

    // Refill, then an issue while full is dropped; issue plus pop keeps three entries.
    step("refill", 5'd1, 5'd5, 6'd0, 4'd0, 32'd50, 32'd1, 32'd0, 1'b0, 1'b0);
    check("refill.not_free", 32'(fu_free), 32'd0);
    step("drop", 5'd1, 5'd6, 6'd0, 4'd0, 32'd60, 32'd1, 32'd0, 1'b0, 1'b1);
    check("drop.head", 32'(cdb_roben), 32'd3);
    check("drop.free", 32'(fu_free),   32'd1);
    step("pushpop", 5'd1, 5'd7, 6'd0, 4'd0, 32'd70, 32'd1, 32'd0, 1'b0, 1'b1);
    check("pushpop.head", 32'(cdb_roben), 32'd4);
    idle("drain", 1'b1);
    check("drain.head5", 32'(cdb_roben), 32'd5);
    idle("drain", 1'b1);
    check("drain.head7", 32'(cdb_roben), 32'd7);
    check("drain.val7",  cdb_val,        32'd71);
    idle("drain", 1'b1);
    check("drain.empty", 32'(cdb_req), 32'd0);

    // Signed/unsigned compares against an immediate, and arithmetic right shift.
    step("slt", 5'd2, 5'd10, 6'd1, 4'd9, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1'b1);
    check("slt.const", cdb_val, 32'd1);
    step("sltu", 5'd2, 5'd11, 6'd1, 4'd10, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1'b1);
    check("sltu.const", cdb_val, 32'd0);
    step("sra", 5'd2, 5'd12, 6'd0, 4'd8, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 1'b1);
    check("sra.const", cdb_val, 32'hF800_0000);
    idle("sra.pop", 1'b1);

    // Flush with queued results empties everything.
    step("q1", 5'd1, 5'd13, 6'd0, 4'd1, 32'd9, 32'd4, 32'd0, 1'b0, 1'b0);
    step("flush", 5'd1, 5'd14, 6'd0, 4'd0, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1);
    check("flush.req", 32'(cdb_req), 32'd0);

`ifdef FU_MUL_EN
    step("mul", 5'd1, 5'd9, 6'd0, 4'd11, 32'd6, 32'd7, 32'd0, 1'b0, 1'b0);
    check("mul.busy0", 32'(fu_free), 32'd0);
    for (int i = 1; i < MUL_CYCLES; i++) begin
      idle("mul.wait", 1'b0);
      check("mul.busy", 32'(fu_free), 32'd0);
      check("mul.noreq", 32'(cdb_req), 32'd0);
    end
    idle("mul.done", 1'b0);
    check("mul.val",   cdb_val,          32'd42);
    check("mul.roben", 32'(cdb_roben),   32'd9);
    check("mul.free",  32'(fu_free),     32'd1);
    idle("mul.pop", 1'b1);

    step("mulf", 5'd1, 5'd9, 6'd0, 4'd11, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1);
    idle("mulf.wait", 1'b1);
    step("mulf.flush", 5'd0, 5'd0, 6'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    check("mulf.free", 32'(fu_free), 32'd1);
    for (int i = 0; i < MUL_CYCLES; i++) idle("mulf.after", 1'b0);
    check("mulf.noreq", 32'(cdb_req), 32'd0);

    step("mulr", 5'd1, 5'd9, 6'd0, 4'd11, 32'd6, 32'd7, 32'd0, 1'b0, 1'b0);
    idle("mulr.wait", 1'b0);
    do_reset("mulr.reset");
    for (int i = 0; i < MUL_CYCLES; i++) idle("mulr.after", 1'b0);
    check("mulr.noreq", 32'(cdb_req), 32'd0);
`else
    step("op11", 5'd1, 5'd9, 6'd0, 4'd11, 32'd6, 32'd7, 32'd0, 1'b0, 1'b0);
    check("op11.zero",  cdb_val,        32'd0);
    check("op11.roben", 32'(cdb_roben), 32'd9);
    idle("op11.pop", 1'b1);
`endif

    // Random traffic: mixed issue/grant/flush pressure with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rnd.reset");
      end else begin
        step("rnd",
             ($urandom_range(0, 3) != 0) ? 5'($urandom_range(1, 31)) : 5'd0,
             5'($urandom_range(1, 31)),
             ($urandom_range(0, 1) != 0) ? 6'd0 : 6'($urandom_range(1, 63)),
             4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom(),
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom(),
             $urandom(),
             ($urandom_range(0, 31) == 0),
             ($urandom_range(0, 2) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
